ser_bus_tx: RTL
===============

// Module: ser_bus_tx
// PURPOSE
//  Bus-side serializer: the transmitting end of the 73-bit shared BUS whose receiving end is
//  the per-block deserializer. Latches one request (header + up to 16B), asks the bus arbiter
//  (BAU) for the bus, then drives 1-4 32-bit beats that the target deserializer captures
//  chunk-by-chunk. Tri-states BUS whenever it does not own it.
// PARAMETERS
//  loc   0   4-bit ID of this unit; driven on the BUS return field of every beat
// PORTS
//  clk_bus  in     1    bus clock (only clock)
//  rst      in     1    asynchronous, active-low reset
//  send     in     1    request strobe from block; accepted only when full==0
//  pAdr     in     15   physical address
//  data     in     128  payload; chunk i = data[32*i+31:32*i]
//  dest     in     4    target unit ID
//  rw       in     1    read/write flag, passed through
//  size     in     16   payload length in bytes
//  full     out    1    request buffer occupied; send ignored while 1
//  req      out    1    bus request to BAU
//  grant    in     1    BAU grant; BAU asserts target setReciever in the same cycle
//  done     out    1    one-cycle pulse in the cycle after the last beat
//  BUS      inout  73   [0]valid [15:1]pAdr [47:16]data [51:48]return [55:52]dest [56]rw [72:57]size
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; full=0, req=0, done=0; BUS all-Z at once; buffer cleared.
//  Beat count N = 1 if size==0, else min(4, ceil(size/4)); computed and latched at accept.
//  States:
//   IDLE: send=1 -> latch pAdr/data/dest/rw/N; full=1 next cycle; go REQ.
//   REQ:  req=1. Stay until grant sampled 1 at a clk_bus edge; then go XFER with k=N-1.
//   XFER: drive one beat per cycle, chunks k = N-1 down to 0; req=0.
//         Beat fields: valid=1; pAdr, dest, rw latched; return=loc; data=chunk k;
//         size[3:0]=one-hot bit k; size[15:4]=0.
//         Beat with k==0 is the last (it moves the receiver to full). Next edge: go IDLE,
//         full=0, done=1 for one cycle, BUS back to Z.
//  Latency: first beat is driven in the cycle after the grant edge, i.e. the receiver's
//   first capture cycle. The request is never mid-stream-aborted except by reset.
//  BUS is driven only in XFER. Outside XFER all 73 bits are Z (no idle valid=0 drive);
//   the bus pull-down supplies valid=0.
//  Boundaries:
//   - send while full=1 is ignored, incl. the last-beat cycle; next send is accepted in IDLE.
//   - send and grant in the same cycle in IDLE: accept only; grant ignored, no beat.
//   - grant in IDLE or XFER is ignored.
//   - Grant held >1 cycle in REQ has the same effect as 1 cycle.
//   - size>16 clamps to 4 beats; data beyond 16B is not sent.
//   - rst low mid-XFER: BUS to Z immediately, state IDLE, no done pulse.
//  No combinational path from any input to BUS or to req.
// TESTING
//  T1 reset: rst=0 during XFER -> BUS all Z same cycle; full=req=done=0 after release.
//  T2 size=16, data=0x33..,0x22..,0x11..,0x00.., dest=2, loc=5, grant 3 cycles after send
//     -> beats chunk3..0 on 4 consecutive cycles starting the cycle after grant.
//     -> size[3:0] sequence 8,4,2,1; return=5; dest=2; done pulse once; full clears.
//  T3 size=0 and size=4 -> exactly 1 beat, size[3:0]=1.
//     size=5 -> 2 beats (2,1). size=40 -> 4 beats.
//  T4 send pulses while full=1 (REQ and XFER) -> ignored; latched header unchanged on BUS.
//     send in the done cycle -> accepted; req rises next cycle.
//  T5 grant while IDLE -> no BUS drive.
//     send+grant same cycle -> req asserted next cycle; beats only after a later grant.
//  T6 with a deserializer connected at dest -> receiver captures all 128 bits/pAdr/rw exactly.

Source files
------------

// File: rtl/ser_bus_tx_if.sv
// Block/arbiter-side handshake of the bus serializer: request fields, buffer status,
// arbiter request/grant and the completion pulse.
interface ser_bus_tx_if;
    logic         send;
    logic [14:0]  pAdr;
    logic [127:0] data;
    logic [3:0]   dest;
    logic         rw;
    logic [15:0]  size;
    logic         full;
    logic         req;
    logic         grant;
    logic         done;

    modport master (
        output send, pAdr, data, dest, rw, size, grant,
        input  full, req, done
    );

    modport slave (
        input  send, pAdr, data, dest, rw, size, grant,
        output full, req, done
    );
endinterface

// File: rtl/ser_bus_tx.sv
// Bus-side serializer: buffers one request, arbitrates for the shared 73-bit bus and drives
// 1-4 beats (highest chunk first), tri-stating the bus whenever it does not own it.
module ser_bus_tx #(
    parameter logic [3:0] loc = 4'd0
) (
    input  logic        clk_bus,
    input  logic        rst,
    ser_bus_tx_if.slave bus_if,
    inout  wire  [72:0] BUS
);
    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e       state_q;
    logic [14:0]  padr_q;
    logic [127:0] data_q;
    logic [3:0]   dest_q;
    logic         rw_q;
    logic [1:0]   chunk_q;
    logic         full_q;
    logic         req_q;
    logic         done_q;
    logic         drive_q;
    logic [72:0]  beat_q;

    logic [15:0]  size_m1;
    logic [1:0]   last_chunk;

    // Index of the first (highest) chunk: beats = 1 for size 0, else min(4, ceil(size/4)).
    always_comb begin
        size_m1 = bus_if.size - 16'd1;
        if (bus_if.size == 16'd0) begin
            last_chunk = 2'd0;
        end else if (bus_if.size > 16'd12) begin
            last_chunk = 2'd3;
        end else begin
            last_chunk = size_m1[3:2];
        end
    end

    function automatic logic [72:0] make_beat(
        input logic [1:0]   k,
        input logic [14:0]  adr,
        input logic [127:0] dat,
        input logic [3:0]   dst,
        input logic         wr
    );
        logic [15:0] sz;
        sz = 16'd1 << k;
        return {sz, wr, dst, loc, dat[{k, 5'b0} +: 32], adr, 1'b1};
    endfunction

    always_ff @(posedge clk_bus or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            padr_q  <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            chunk_q <= '0;
            full_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            drive_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_if.send) begin
                        padr_q  <= bus_if.pAdr;
                        data_q  <= bus_if.data;
                        dest_q  <= bus_if.dest;
                        rw_q    <= bus_if.rw;
                        chunk_q <= last_chunk;
                        full_q  <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (bus_if.grant) begin
                        req_q   <= 1'b0;
                        drive_q <= 1'b1;
                        beat_q  <= make_beat(chunk_q, padr_q, data_q, dest_q, rw_q);
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    // Chunk 0 is always the final beat; it completes the receiver.
                    if (chunk_q == 2'd0) begin
                        drive_q <= 1'b0;
                        full_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        chunk_q <= chunk_q - 2'd1;
                        beat_q  <= make_beat(chunk_q - 2'd1, padr_q, data_q, dest_q, rw_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_if.full = full_q;
    assign bus_if.req  = req_q;
    assign bus_if.done = done_q;
    assign BUS = drive_q ? beat_q : {73{1'bz}};

endmodule
